// File: rtl/rtc_bcd.sv
// Free-running BCD real-time clock: seconds through century plus day-of-week,
// advanced once per CLK_FREQ enabled cycles and loadable as one 60-bit word.
module rtc_bcd #(
  parameter int unsigned CLK_FREQ = 86000000
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        rtc_en,
  input  logic        rtc_we,
  input  logic [59:0] rtc_data_in,
  output logic [59:0] rtc_data,
  output logic        tick_1hz
);

  localparam int unsigned     PW      = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]   TERM    = PW'(CLK_FREQ - 1);
  localparam logic [59:0]     RST_VAL = 60'h620000101000000;

  logic [PW-1:0] presc_q, presc_d;
  logic [59:0]   data_q, data_d;
  logic          tick_q, tick_d;

  logic [7:0] sec, min, hour, day, mon, year, cen;
  logic [3:0] dow;
  assign sec  = data_q[7:0];
  assign min  = data_q[15:8];
  assign hour = data_q[23:16];
  assign day  = data_q[31:24];
  assign mon  = data_q[39:32];
  assign year = data_q[47:40];
  assign cen  = data_q[55:48];
  assign dow  = data_q[59:56];

  // Limits compare against the raw packed byte so garbage loads still roll over.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim,
                                         input logic [7:0] wrap);
    logic [7:0] r;
    if (v >= lim)
      r = wrap;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic mult4(input logic [7:0] v);
    logic r;
    if (!v[4])
      r = (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    else
      r = (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
    return r;
  endfunction

  logic       leap;
  logic [7:0] dim;
  logic       min_c, hour_c, day_c, mon_c, year_c, cen_c;
  logic [59:0] data_inc;

  always_comb begin
    leap = (year == 8'h00) ? mult4(cen) : mult4(year);
    dim  = 8'h31;
    case (mon)
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      8'h02:                      dim = leap ? 8'h29 : 8'h28;
      default:                    dim = 8'h31;
    endcase

    min_c  = (sec  >= 8'h59);
    hour_c = min_c  && (min  >= 8'h59);
    day_c  = hour_c && (hour >= 8'h23);
    mon_c  = day_c  && (day  >= dim);
    year_c = mon_c  && (mon  >= 8'h12);
    cen_c  = year_c && (year >= 8'h99);

    data_inc         = data_q;
    data_inc[7:0]    = bcd_inc(sec, 8'h59, 8'h00);
    if (min_c)  data_inc[15:8]  = bcd_inc(min,  8'h59, 8'h00);
    if (hour_c) data_inc[23:16] = bcd_inc(hour, 8'h23, 8'h00);
    if (day_c) begin
      data_inc[31:24] = bcd_inc(day, dim, 8'h01);
      data_inc[59:56] = (dow >= 4'd6) ? 4'd0 : dow + 4'd1;
    end
    if (mon_c)  data_inc[39:32] = bcd_inc(mon,  8'h12, 8'h01);
    if (year_c) data_inc[47:40] = bcd_inc(year, 8'h99, 8'h00);
    if (cen_c)  data_inc[55:48] = bcd_inc(cen,  8'h99, 8'h00);
  end

  // A load on the terminal-count edge suppresses that second entirely.
  always_comb begin
    presc_d = presc_q;
    data_d  = data_q;
    tick_d  = 1'b0;
    if (rtc_we) begin
      data_d  = rtc_data_in;
      presc_d = '0;
    end else if (rtc_en) begin
      if (presc_q == TERM) begin
        presc_d = '0;
        data_d  = data_inc;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      data_q  <= RST_VAL;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
    end
  end

  assign rtc_data = data_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_rtc_bcd.sv
// Scoreboard bench for rtc_bcd: the driver predicts each second with a calendar
// model and queues it; a monitor checks every tick_1hz against the queue.
module tb_rtc_bcd;

  localparam int          F       = 4;
  localparam logic [59:0] RST_VAL = 60'h620000101000000;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        rtc_en = 1'b0;
  logic        rtc_we = 1'b0;
  logic [59:0] rtc_data_in = '0;
  logic [59:0] rtc_data;
  logic        tick_1hz;

  rtc_bcd #(.CLK_FREQ(F)) dut (
    .clkin(clkin), .rst_n(rst_n), .rtc_en(rtc_en), .rtc_we(rtc_we),
    .rtc_data_in(rtc_data_in), .rtc_data(rtc_data), .tick_1hz(tick_1hz)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [59:0] d; int c; } exp_t;
  exp_t sb[$];

  logic [59:0] mt;
  int          mcnt;

  function automatic int b2i(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int days_in(int ce, int yr, int mo);
    int  y;
    bit  lp;
    y  = ce * 100 + yr;
    lp = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    case (mo)
      2:            return lp ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  function automatic logic [7:0] roll(logic [7:0] v, logic [7:0] lim, logic [7:0] wrap,
                                      output bit c);
    if (v >= lim) begin
      c = 1'b1;
      return wrap;
    end
    c = 1'b0;
    return i2b(b2i(v) + 1);
  endfunction

  function automatic logic [59:0] model_next(logic [59:0] t);
    logic [7:0] f[7];
    logic [3:0] dw;
    logic [7:0] lim;
    bit         c;
    for (int k = 0; k < 7; k++) f[k] = t[8*k +: 8];
    dw   = t[59:56];
    f[0] = roll(f[0], 8'h59, 8'h00, c);
    if (c) f[1] = roll(f[1], 8'h59, 8'h00, c);
    if (c) f[2] = roll(f[2], 8'h23, 8'h00, c);
    if (c) begin
      dw   = (dw >= 4'd6) ? 4'd0 : dw + 4'd1;
      lim  = i2b(days_in(b2i(f[6]), b2i(f[5]), b2i(f[4])));
      f[3] = roll(f[3], lim, 8'h01, c);
    end
    if (c) f[4] = roll(f[4], 8'h12, 8'h01, c);
    if (c) f[5] = roll(f[5], 8'h99, 8'h00, c);
    if (c) f[6] = roll(f[6], 8'h99, 8'h00, c);
    return {dw, f[6], f[5], f[4], f[3], f[2], f[1], f[0]};
  endfunction

  function automatic logic [59:0] mk(logic [3:0] dw, logic [7:0] ce, logic [7:0] yr,
                                     logic [7:0] mo, logic [7:0] dy, logic [7:0] hr,
                                     logic [7:0] mi, logic [7:0] se);
    return {dw, ce, yr, mo, dy, hr, mi, se};
  endfunction

  function automatic logic [59:0] rand_time();
    int ce, yr, mo, dm, dy, hr, mi, se, dw;
    ce = $urandom_range(0, 99);
    yr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 99);
    mo = $urandom_range(1, 12);
    dm = days_in(ce, yr, mo);
    dy = $urandom_range(0, 1) ? dm : $urandom_range(1, dm);
    hr = $urandom_range(0, 1) ? 23 : $urandom_range(0, 23);
    mi = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
    se = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
    dw = $urandom_range(0, 6);
    return mk(4'(dw), i2b(ce), i2b(yr), i2b(mo), i2b(dy), i2b(hr), i2b(mi), i2b(se));
  endfunction

  // Apply one cycle of inputs at a negedge and predict what the coming edge does.
  task automatic drive(input bit we, input logic [59:0] din, input bit en);
    rtc_we      = we;
    rtc_data_in = din;
    rtc_en      = en;
    if (we) begin
      mt   = din;
      mcnt = 0;
    end else if (en) begin
      if (mcnt == F - 1) begin
        mcnt = 0;
        mt   = model_next(mt);
        sb.push_back('{d: mt, c: cyc + 1});
      end else begin
        mcnt++;
      end
    end
    @(negedge clkin);
  endtask

  task automatic chk(input string nm, input logic [59:0] got, input logic [59:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic sb_empty(input string nm);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s pending_ticks=%0d exp=0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic load_run(input logic [59:0] din, input logic [59:0] exp, input string nm);
    drive(1'b1, din, 1'b1);
    repeat (F) drive(1'b0, '0, 1'b1);
    chk(nm, rtc_data, exp);
    chk({nm, "_tick"}, {59'd0, tick_1hz}, 60'd1);
    sb_empty({nm, "_sb"});
  endtask

  always @(posedge clkin) begin
    exp_t e;
    #1;
    if (tick_1hz === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL tick_unexpected cyc=%0d got=%h exp=no_tick", cyc, rtc_data);
      end else begin
        e = sb.pop_front();
        if (rtc_data !== e.d || cyc != e.c) begin
          bad++;
          $display("FAIL tick_data got=%h@%0d exp=%h@%0d", rtc_data, cyc, e.d, e.c);
        end
      end
    end
  end

  logic [59:0] cases_in[7];
  logic [59:0] cases_exp[7];

  initial begin
    cases_in[0] = mk(4'd3, 8'h20, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    cases_exp[0] = mk(4'd4, 8'h20, 8'h00, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    cases_in[1] = mk(4'd3, 8'h21, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    cases_exp[1] = mk(4'd4, 8'h21, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    cases_in[2] = mk(4'd3, 8'h20, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    cases_exp[2] = mk(4'd4, 8'h20, 8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    cases_in[3] = mk(4'd3, 8'h20, 8'h24, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
    cases_exp[3] = mk(4'd4, 8'h20, 8'h24, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    cases_in[4] = mk(4'd3, 8'h20, 8'h23, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59);
    cases_exp[4] = mk(4'd4, 8'h20, 8'h23, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00);
    cases_in[5] = mk(4'd6, 8'h20, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    cases_exp[5] = mk(4'd0, 8'h21, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    cases_in[6] = mk(4'd3, 8'h99, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    cases_exp[6] = mk(4'd4, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

    mt   = RST_VAL;
    mcnt = 0;
    repeat (3) @(negedge clkin);
    chk("rst_data", rtc_data, RST_VAL);
    chk("rst_tick", {59'd0, tick_1hz}, 60'd0);
    rst_n = 1'b1;

    repeat (F - 1) drive(1'b0, '0, 1'b1);
    chk("first_pre", rtc_data, RST_VAL);
    drive(1'b0, '0, 1'b1);
    chk("first_sec", rtc_data, 60'h620000101000001);
    chk("first_tick", {59'd0, tick_1hz}, 60'd1);

    load_run(60'h519991231235959, RST_VAL, "y2k");
    for (int i = 0; i < 7; i++) load_run(cases_in[i], cases_exp[i], $sformatf("cal%0d", i));

    drive(1'b1, mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 8'h29), 1'b1);
    repeat (F - 1) drive(1'b0, '0, 1'b1);
    drive(1'b1, mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 8'h30), 1'b1);
    chk("coll_data", rtc_data, mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 8'h30));
    chk("coll_tick", {59'd0, tick_1hz}, 60'd0);
    repeat (F - 1) drive(1'b0, '0, 1'b1);
    chk("coll_hold", rtc_data, mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 8'h30));
    drive(1'b0, '0, 1'b1);
    chk("coll_next", rtc_data, mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h12, 8'h00, 8'h31));
    load_run(mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h10, 8'h05, 8'h7A),
             mk(4'd3, 8'h20, 8'h24, 8'h06, 8'h15, 8'h10, 8'h06, 8'h00), "bad_sec");

    drive(1'b1, mk(4'd2, 8'h20, 8'h25, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    repeat (10) drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("en_hold", rtc_data, mk(4'd2, 8'h20, 8'h25, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07));
    drive(1'b0, '0, 1'b1);
    chk("en_resume", rtc_data, mk(4'd2, 8'h20, 8'h25, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08));
    sb_empty("en_sb");

    drive(1'b1, mk(4'd1, 8'h20, 8'h30, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11), 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1);
    #2 rst_n = 1'b0;
    mt   = RST_VAL;
    mcnt = 0;
    #1;
    chk("midrst_data", rtc_data, RST_VAL);
    chk("midrst_tick", {59'd0, tick_1hz}, 60'd0);
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (F - 1) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("midrst_first", rtc_data, 60'h620000101000001);

    for (int t = 0; t < 60; t++) begin
      drive(1'b1, rand_time(), 1'b1);
      for (int c = 0; c < 12; c++) begin
        if ($urandom_range(0, 15) == 0)
          drive(1'b1, rand_time(), $urandom_range(0, 1) == 1);
        else
          drive(1'b0, '0, $urandom_range(0, 3) != 0);
      end
    end
    repeat (2) drive(1'b0, '0, 1'b0);
    sb_empty("final_sb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
